stopwatch_ctrl: RTL

- Control FSM and BCD time-keeping core for the stopwatch.
- Consumes the 1 Hz square-wave tick from the second timebase and debounced button levels (start/stop, lap, clear).
- Produces run/clear controls for the timebase and an mm:ss BCD value for the display driver, with lap-freeze support.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bcd_mmss_counter.sv | 66 ++++++
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control core.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } sw_state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } mmss_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_mmss_counter.sv
// mm:ss BCD counter with a single-cycle carry cascade and wrap at MINUTES_MAX:59.
module bcd_mmss_counter
   import stopwatch_pkg::*;
#(
   parameter int MINUTES_MAX = 59
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  clr,
   input  logic  inc,
   output mmss_t value,
   output logic  wrap
);

   localparam bcd_t MAX_TENS = bcd_t'(MINUTES_MAX / 10);
   localparam bcd_t MAX_ONES = bcd_t'(MINUTES_MAX % 10);

   mmss_t value_reg;
   mmss_t value_next;
   logic  at_max_minutes;

   assign at_max_minutes = (value_reg.min_tens == MAX_TENS) &&
                           (value_reg.min_ones == MAX_ONES);

   // Next count: ripple the carry through all four digits in one cycle.
   always_comb begin
      value_next = value_reg;
      wrap       = 1'b0;
      if (inc) begin
         if (value_reg.sec_ones != BCD_DIGIT_MAX) begin
            value_next.sec_ones = value_reg.sec_ones + 4'd1;
         end else begin
            value_next.sec_ones = '0;
            if (value_reg.sec_tens != SEC_TENS_MAX) begin
               value_next.sec_tens = value_reg.sec_tens + 4'd1;
            end else begin
               value_next.sec_tens = '0;
               if (at_max_minutes) begin
                  value_next.min_tens = '0;
                  value_next.min_ones = '0;
                  wrap                = 1'b1;
               end else if (value_reg.min_ones != BCD_DIGIT_MAX) begin
                  value_next.min_ones = value_reg.min_ones + 4'd1;
               end else begin
                  value_next.min_ones = '0;
                  value_next.min_tens = value_reg.min_tens + 4'd1;
               end
            end
         end
      end
   end

   // Count register; a clear request overrides any increment in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_reg <= '0;
      end else if (clr) begin
         value_reg <= '0;
      end else begin
         value_reg <= value_next;
      end
   end

   assign value = value_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detection, second counting, lap freeze.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MINUTES_MAX = 59
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        btn_start_stop,
   input  logic        btn_lap,
   input  logic        btn_clear,
   output logic        tb_run,
   output logic        tb_clear,
   output logic [15:0] disp_digits,
   output logic [15:0] live_digits,
   output logic [1:0]  state,
   output logic        rollover
);

   localparam int BTN_LAP = 0;
   localparam int BTN_SS  = 1;
   localparam int BTN_CLR = 2;

   logic [2:0] btn_level;
   logic [2:0] btn_prev_reg;
   logic [2:0] btn_armed_reg;
   logic [2:0] btn_evt_reg;

   logic       clr_evt;
   logic       ss_evt;
   logic       lap_evt;

   logic       tick_prev_reg;
   logic       sec_evt;
   logic       cnt_inc;

   sw_state_t  state_reg;
   sw_state_t  state_next;
   logic       cnt_clr;
   logic       lap_load;
   logic       roll_clr;

   mmss_t      live_value;
   mmss_t      lap_reg;
   logic       cnt_wrap;
   logic       rollover_reg;

   assign btn_level = {btn_clear, btn_start_stop, btn_lap};

   // A button is armed only after it has been seen released, so a level
   // held across reset release never produces an event.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         // Registered rising-edge detector for one button.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               btn_prev_reg[gi]  <= 1'b0;
               btn_armed_reg[gi] <= 1'b0;
               btn_evt_reg[gi]   <= 1'b0;
            end else begin
               btn_prev_reg[gi]  <= btn_level[gi];
               btn_armed_reg[gi] <= btn_armed_reg[gi] | ~btn_level[gi];
               btn_evt_reg[gi]   <= btn_level[gi] & ~btn_prev_reg[gi] & btn_armed_reg[gi];
            end
         end
      end
   endgenerate

   // Resolve simultaneous events: clear beats start/stop beats lap.
   always_comb begin
      clr_evt = btn_evt_reg[BTN_CLR];
      ss_evt  = btn_evt_reg[BTN_SS] & ~btn_evt_reg[BTN_CLR];
      lap_evt = btn_evt_reg[BTN_LAP] & ~btn_evt_reg[BTN_SS] & ~btn_evt_reg[BTN_CLR];
   end

   assign sec_evt = tick_prev_reg & ~tick;
   assign cnt_inc = sec_evt & ((state_reg == RUN) || (state_reg == LAP));

   // Next-state and control strobes from the registered state and events.
   always_comb begin
      state_next = state_reg;
      tb_clear   = 1'b0;
      cnt_clr    = 1'b0;
      lap_load   = 1'b0;
      roll_clr   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ss_evt) begin
               state_next = RUN;
               tb_clear   = 1'b1;
            end
         end
         RUN: begin
            if (ss_evt) begin
               state_next = PAUSE;
            end else if (lap_evt) begin
               state_next = LAP;
               lap_load   = 1'b1;
            end
         end
         LAP: begin
            if (ss_evt) begin
               state_next = PAUSE;
            end else if (lap_evt) begin
               state_next = RUN;
            end
         end
         PAUSE: begin
            if (clr_evt) begin
               state_next = IDLE;
               tb_clear   = 1'b1;
               cnt_clr    = 1'b1;
               roll_clr   = 1'b1;
            end else if (ss_evt) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Tick history; forced low when the timebase is cleared so no stale edge is seen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_prev_reg <= 1'b0;
      end else if (tb_clear) begin
         tick_prev_reg <= 1'b0;
      end else begin
         tick_prev_reg <= tick;
      end
   end

   // Lap latch captures the pre-increment live count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lap_reg <= '0;
      end else if (lap_load) begin
         lap_reg <= live_value;
      end
   end

   // Sticky rollover flag, cleared only by a clear from PAUSE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rollover_reg <= 1'b0;
      end else if (roll_clr) begin
         rollover_reg <= 1'b0;
      end else if (cnt_wrap) begin
         rollover_reg <= 1'b1;
      end
   end

   bcd_mmss_counter #(
      .MINUTES_MAX (MINUTES_MAX)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .value (live_value),
      .wrap  (cnt_wrap)
   );

   assign tb_run      = (state_reg == RUN) || (state_reg == LAP);
   assign live_digits = live_value;
   assign disp_digits = (state_reg == LAP) ? lap_reg : live_value;
   assign state       = state_reg;
   assign rollover    = rollover_reg;

endmodule
